// File: rtl/rsa_keygen.sv
// rsa_keygen: computes n = p*q and phi = (p-1)(q-1), drives an external ext-GCD engine and returns d = e^-1 mod phi.
// Define RSA_KEYGEN_CONST_TIME_EN to keep invalid-parameter runs at full latency with dummy GCD operands.
module rsa_keygen #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   p,
    input  logic [WIDTH-1:0]   q,
    input  logic [2*WIDTH-1:0] e,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] n,
    output logic [2*WIDTH-1:0] d,
    output logic               error,
    output logic               gcd_start,
    output logic [2*WIDTH-1:0] gcd_a,
    output logic [2*WIDTH-1:0] gcd_b,
    input  logic [2*WIDTH-1:0] gcd_val,
    input  logic [2*WIDTH-1:0] gcd_t,
    input  logic               gcd_finish
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, MUL_N, MUL_PHI, CHECK, GCD_REQ, GCD_WAIT, FIX, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] p_r, q_r, mplier;
    logic [W2-1:0]    e_r, acc, acc_nxt, mcand, gv, gt;
    logic [CW-1:0]    cnt;
    logic             last, in_err, gcd_bad;

    // Every multiply cycle adds either 0 or the multiplicand, so latency never depends on data.
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    assign last    = cnt == LAST;
    // acc holds phi from CHECK onwards; a set phi MSB would make the sign of t ambiguous.
    assign in_err  = (p_r[WIDTH-1:1] == '0) || (q_r[WIDTH-1:1] == '0) || (e_r == '0) || (e_r >= acc) || acc[W2-1];
    assign gcd_bad = gv != W2'(1);

    assign busy      = !(state == IDLE || state == DONE);
    assign done      = state == DONE;
    assign gcd_start = state == GCD_REQ;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = start ? MUL_N : IDLE;
            MUL_N:    state_nxt = last ? MUL_PHI : MUL_N;
            MUL_PHI:  state_nxt = last ? CHECK : MUL_PHI;
`ifdef RSA_KEYGEN_CONST_TIME_EN
            CHECK:    state_nxt = GCD_REQ;
`else
            CHECK:    state_nxt = in_err ? DONE : GCD_REQ;
`endif
            GCD_REQ:  state_nxt = GCD_WAIT;
            GCD_WAIT: state_nxt = gcd_finish ? FIX : GCD_WAIT;
            FIX:      state_nxt = DONE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r    <= '0;
            q_r    <= '0;
            e_r    <= '0;
            mplier <= '0;
            mcand  <= '0;
            acc    <= '0;
            cnt    <= '0;
            gv     <= '0;
            gt     <= '0;
            n      <= '0;
            d      <= '0;
            error  <= 1'b0;
            gcd_a  <= '0;
            gcd_b  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    p_r    <= p;
                    q_r    <= q;
                    e_r    <= e;
                    mcand  <= {{WIDTH{1'b0}}, p};
                    mplier <= q;
                    acc    <= '0;
                    cnt    <= '0;
                    d      <= '0;
                    error  <= 1'b0;
                end
                MUL_N, MUL_PHI: begin
                    cnt    <= last ? '0 : cnt + 1'b1;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    acc    <= acc_nxt;
                    if (state == MUL_N && last) begin
                        n      <= acc_nxt;
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, p_r - 1'b1};
                        mplier <= q_r - 1'b1;
                    end
                end
                CHECK: begin
                    error <= in_err;
                    gcd_a <= in_err ? W2'(1) : acc;
                    gcd_b <= in_err ? W2'(1) : e_r;
                end
                GCD_WAIT: if (gcd_finish) begin
                    gv <= gcd_val;
                    gt <= gcd_t;
                end
                FIX: begin
                    error <= error | gcd_bad;
                    d     <= (error || gcd_bad) ? '0 : gt[W2-1] ? gt + acc : gt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_keygen.sv
// tb_rsa_keygen: fixed-latency (G=20) ext-GCD engine model plus an arithmetic reference for n, d, error and cycle timing.
module tb_rsa_keygen;
`ifdef RSA_KEYGEN_CONST_TIME_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif
    localparam int G = 20;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [7:0]  p = '0, q = '0;
    logic [15:0] e = '0, gcd_val = '0, gcd_t = '0;
    logic        gcd_finish = 1'b0;
    logic        busy, done, error, gcd_start;
    logic [15:0] n, d, gcd_a, gcd_b;

    rsa_keygen #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .p(p), .q(q), .e(e),
        .busy(busy), .done(done), .n(n), .d(d), .error(error),
        .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
        .gcd_val(gcd_val), .gcd_t(gcd_t), .gcd_finish(gcd_finish)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d cyc=%0d", nm, got, exp, cyc);
        end
    endtask

    // Reference model of the current request
    bit     act = 1'b0, use_gcd = 1'b0, exp_err = 1'b0;
    int     c0 = 0, lat = 0;
    longint exp_n = 0, exp_d = 0, prev_n = 0, exp_ga = 0, exp_gb = 0;

    task automatic model_start(input longint pp, input longint qq, input longint ee);
        longint ph;
        bit     in_err, gcd_bad;
        ph = ((pp + 255) % 256) * ((qq + 255) % 256);
        in_err  = pp < 2 || qq < 2 || ee == 0 || ee >= ph || ph >= 32768;
        gcd_bad = 1'b1;
        exp_d   = 0;
        if (!in_err)
            for (longint k = 1; k < ph; k++)
                if ((ee * k) % ph == 1) begin
                    exp_d   = k;
                    gcd_bad = 1'b0;
                    break;
                end
        exp_err = in_err || gcd_bad;
        lat     = (in_err && !CT) ? 18 : 16 + G + 4;
        use_gcd = !(in_err && !CT);
        exp_ga  = in_err ? 1 : ph;
        exp_gb  = in_err ? 1 : ee;
        prev_n  = act ? exp_n : prev_n;
        exp_n   = pp * qq;
        c0      = cyc;
        act     = 1'b1;
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (rst_n) begin
            int off;
            off = cyc - c0;
            chk("busy", busy, act && off >= 1 && off < lat);
            chk("done", done, act && off == lat);
            chk("gcd_start", gcd_start, act && use_gcd && off == 18);
            chk("n_hold", n, (act && off >= 9) ? exp_n : prev_n);
            if (act && off == lat) begin
                chk("d", d, exp_d);
                chk("error", error, exp_err);
            end
            if (act && use_gcd && off >= 18 && off <= 18 + G) begin
                chk("gcd_a", gcd_a, exp_ga);
                chk("gcd_b", gcd_b, exp_gb);
            end
        end
    end

    // GCD engine model: extended Euclid, result after exactly G cycles
    int     n_gs = 0;
    longint eng_a = 0, eng_b = 0;

    function automatic void egcd(input longint a, input longint b, output longint g, output longint t);
        longint r0, r1, t0, t1, qq, tmp;
        r0 = a; r1 = b; t0 = 0; t1 = 1;
        while (r1 != 0) begin
            qq = r0 / r1;
            tmp = r0 - qq * r1; r0 = r1; r1 = tmp;
            tmp = t0 - qq * t1; t0 = t1; t1 = tmp;
        end
        g = r0;
        t = t0;
    endfunction

    initial forever begin
        @(negedge clk);
        if (rst_n && gcd_start) begin
            longint g, t;
            eng_a = gcd_a;
            eng_b = gcd_b;
            n_gs++;
            egcd(eng_a, eng_b, g, t);
            repeat (G) @(negedge clk);
            gcd_val    = 16'(g);
            gcd_t      = 16'(t);
            gcd_finish = 1'b1;
            @(negedge clk);
            gcd_finish = 1'b0;
            gcd_val    = 16'($urandom);
            gcd_t      = 16'($urandom);
        end
    end

    // Driver
    int     dc, doff;
    longint dn, dd, derr;

    task automatic kick(input int pp, input int qq, input int ee);
        @(negedge clk);
        p = 8'(pp); q = 8'(qq); e = 16'(ee);
        start = 1'b1;
        model_start(pp, qq, ee);
        @(negedge clk);
        start = 1'b0;
        p = 8'($urandom); q = 8'($urandom); e = 16'($urandom);
    endtask

    task automatic run(input int pp, input int qq, input int ee, input bit second);
        kick(pp, qq, ee);
        dc = 0; doff = -1;
        for (int k = 2; k < 50; k++) begin
            if (done) begin
                dc++; doff = cyc - c0; dn = n; dd = d; derr = error;
            end
            start = second && (cyc - c0 == 4);
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_count", dc, 1);
    endtask

    initial begin
        int gs0, sd;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_n_out", n, 0);
        chk("rst_d", d, 0);
        chk("rst_gcd_start", gcd_start, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(61, 53, 17, 1'b0);
        chk("neg_t_n", dn, 3233);
        chk("neg_t_d", dd, 2753);
        chk("neg_t_err", derr, 0);
        chk("neg_t_done_cyc", doff, 40);
        chk("neg_t_ga", eng_a, 3120);
        chk("neg_t_gb", eng_b, 17);

        run(5, 11, 9, 1'b0);
        chk("pos_t_n", dn, 55);
        chk("pos_t_d", dd, 9);
        chk("pos_t_err", derr, 0);

        run(61, 53, 15, 1'b0);
        chk("ncop_err", derr, 1);
        chk("ncop_d", dd, 0);
        chk("ncop_n", dn, 3233);
        chk("ncop_done_cyc", doff, 40);

        gs0 = n_gs;
        run(1, 53, 17, 1'b0);
        chk("perr_err", derr, 1);
        chk("perr_d", dd, 0);
        chk("perr_done_cyc", doff, CT ? 40 : 18);
        chk("perr_gcd_starts", n_gs - gs0, CT ? 1 : 0);
        if (n_gs != gs0) begin
            chk("dummy_a", eng_a, 1);
            chk("dummy_b", eng_b, 1);
        end

        gs0 = n_gs;
        run(61, 53, 3120, 1'b0);
        chk("eerr_err", derr, 1);
        chk("eerr_done_cyc", doff, CT ? 40 : 18);
        chk("eerr_gcd_starts", n_gs - gs0, CT ? 1 : 0);

        run(61, 53, 17, 1'b1);
        chk("busy_start_d", dd, 2753);
        chk("busy_start_done_cyc", doff, 40);

        kick(61, 53, 17);
        while (cyc - c0 < 25) @(negedge clk);
        rst_n = 1'b0;
        act = 1'b0;
        prev_n = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_n", n, 0);
        chk("mid_rst_d", d, 0);
        chk("mid_rst_gcd_start", gcd_start, 0);
        chk("mid_rst_gcd_a", gcd_a, 0);
        chk("mid_rst_gcd_b", gcd_b, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) sd++;
        end
        chk("stray_finish_done", sd, 0);

        for (int i = 0; i < 25; i++) begin
            int pp, qq, ee;
            pp = $urandom_range(0, 190);
            qq = $urandom_range(0, 190);
            ee = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : ($urandom_range(1, 300) | 1);
            run(pp, qq, ee, i[0]);
            chk("rand_d", dd, exp_d);
            chk("rand_err", derr, exp_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rsa_keygen.md
# rsa_keygen

Constant-time RSA key-generation controller sitting directly upstream and downstream of the extended-GCD engine. It takes secret primes p, q and public exponent e, and computes n = p·q and φ = (p−1)(q−1) with a shared fixed-latency shift-add multiplier. It then launches the GCD engine on (φ, e), consumes the returned gcd and Bézout coefficient t, and emits the private exponent d = e⁻¹ mod φ, or an error flag.

## Interface
- WIDTH, 8: bit width of p and q; n, φ, e and d are 2*WIDTH bits.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- p, q  in  WIDTH  primes; sampled on the accepted start.
- e  in  2*WIDTH  public exponent; sampled on the accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when n, d and error are valid.
- n  out  2*WIDTH  modulus; held until the next accepted start.
- d  out  2*WIDTH  private exponent; 0 when error is set.
- error  out  1  invalid parameters or gcd(φ, e) ≠ 1; valid with done.
- gcd_start  out  1  one-cycle pulse to the GCD engine.
- gcd_a, gcd_b  out  2*WIDTH  GCD operands (larger, smaller); stable from gcd_start until gcd_finish.
- gcd_val  in  2*WIDTH  gcd result from the engine.
- gcd_t  in  2*WIDTH  Bézout t, two's complement, satisfying s·gcd_a + t·gcd_b = gcd.
- gcd_finish  in  1  engine result-valid pulse.

## Operation
- States: IDLE, MUL_N, MUL_PHI, CHECK, GCD_REQ, GCD_WAIT, FIX, DONE.
- IDLE: on start, latch p, q and e, then go to MUL_N. start in any other state is ignored.
- MUL_N: exactly WIDTH cycles of shift-add. Each cycle examines one multiplier bit; the accumulator is updated every cycle (adds 0 or the shifted multiplicand) so latency is data-independent. Result is n = p·q (2*WIDTH bits, no overflow).
- MUL_PHI: exactly WIDTH cycles on the same datapath to compute φ = (p−1)·(q−1).
- CHECK (1 cycle): raises an input error if p < 2, q < 2, e == 0, e ≥ φ, or φ[2*WIDTH−1] == 1. The last condition is required so that t's sign bit is unambiguous.
- GCD_REQ (1 cycle): gcd_a = φ, gcd_b = e, gcd_start = 1.
- GCD_WAIT: hold the operands and wait for gcd_finish. On gcd_finish, latch gcd_val and gcd_t.
- FIX (1 cycle):
  - If gcd_val ≠ 1, set error = 1 and d = 0.
  - Otherwise, if gcd_t[MSB] == 1, d = gcd_t + φ (mod 2^(2*WIDTH)); else d = gcd_t.
- DONE (1 cycle): done = 1, busy = 0; next state IDLE.
- Reset mid-operation: immediately return to IDLE with all outputs at reset values. A pending gcd_finish arriving in IDLE is ignored.
- Reset values: busy = 0, done = 0, error = 0, n = 0, d = 0, gcd_start = 0, gcd_a = 0, gcd_b = 0.

## Timing
- Start is sampled at edge 0, and busy rises at edge 1.
- gcd_start is high in cycle 2*WIDTH+2, following 2*WIDTH multiply cycles and 1 CHECK cycle.
- G is the number of cycles from gcd_start high to gcd_finish high. Because the engine pads to a fixed latency, G is constant.
- done pulses at cycle 2*WIDTH + G + 4. In the nominal path this is independent of the operand values.
- gcd_finish in the same cycle as gcd_start is impossible by engine contract and is not handled.
- n is registered at the end of MUL_N and is stable from then until the next accepted start.

## Configuration
- RSA_KEYGEN_CONST_TIME_EN defined:
  - An input error from CHECK does not shorten the run.
  - The block still issues gcd_start with dummy operands gcd_a = 1, gcd_b = 1, waits for gcd_finish, and discards the result.
  - error = 1 and d = 0 are reported with done at the same cycle, 2*WIDTH + G + 4, as a valid run.
- RSA_KEYGEN_CONST_TIME_EN undefined:
  - An input error in CHECK goes directly to DONE with no gcd_start.
  - done pulses at cycle 2*WIDTH + 2, with error = 1 and d = 0.

## Test plan
The bench uses a GCD engine model with fixed G = 20 and WIDTH = 8.
- Negative t: p=61, q=53, e=17. The model returns gcd_val=1, t=−367. Required: n=3233, d=2753, error=0, with gcd_a=3120 and gcd_b=17 seen at gcd_start. done at cycle 40.
- Positive t: p=5, q=11, e=9. The model returns gcd_val=1, t=9. Required: n=55, d=9, error=0.
- Not coprime: p=61, q=53, e=15. The model returns gcd_val=15. Required: error=1, d=0, n=3233, done at cycle 40.
- Input error: p=1 or e=3120 with q=53.
  - With the macro defined: dummy gcd_a=gcd_b=1, error=1, done at cycle 40.
  - Without the macro: no gcd_start, done at cycle 18.
- Start while busy: a second start at cycle 5 is ignored, and done fires once for the first request.
- Reset mid-operation: assert rst_n=0 in GCD_WAIT. All outputs return to 0, and a later stray gcd_finish produces no done.
